// File: rtl/water_level_encoder.sv
// Water-level probe encoder: synchronizes, debounces and validates the seven
// probes, then slews a 3-bit level code one step per tick. Optional macro:
// WATER_FAULT_ALARM_EN forces the level to 7 while the pattern is invalid.
module water_level_encoder #(
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] probe,
  output logic [2:0] state,
  output logic       fault,
  output logic       changed
);

  localparam int              DW      = $clog2(TICK_DIV);
  localparam logic [DW-1:0]   DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [3:0]      CNT_MAX = 4'(STABLE_CNT);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [6:0]    sync1, psync, cand, acc;
  logic [3:0]    cnt, cnt_inc;
  logic [2:0]    target, nxt;
  logic          bad;

  assign tick    = (div_cnt == DIV_MAX);
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + 4'd1 : cnt;

  // A valid pattern is a run of ones from bit 0: adding 1 then clears every set bit.
  always_comb begin
    target = 3'd0;
    for (int i = 0; i < 7; i++) target = target + 3'(acc[i]);
    bad = ((({1'b0, acc}) + 8'd1) & {1'b0, acc}) != 8'd0;
  end

  always_comb begin
    nxt = state;
    if (!bad) begin
      if (state < target)      nxt = state + 3'd1;
      else if (state > target) nxt = state - 3'd1;
    end
`ifdef WATER_FAULT_ALARM_EN
    else begin
      nxt = 3'd7;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      psync   <= '0;
      div_cnt <= '0;
      cand    <= '0;
      cnt     <= '0;
      acc     <= '0;
      state   <= '0;
      fault   <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync1   <= probe;
      psync   <= sync1;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      fault   <= bad;
      changed <= 1'b0;
      if (tick) begin
        if (psync == cand) begin
          cnt <= cnt_inc;
          if (cnt_inc == CNT_MAX) acc <= psync;
        end else begin
          cand <= psync;
          cnt  <= 4'd1;
          if (CNT_MAX == 4'd1) acc <= psync;
        end
        // Slew decision uses the acc held before this tick.
        state   <= nxt;
        changed <= (nxt != state);
      end
    end
  end

endmodule

// File: tb/tb_water_level_encoder.sv
// Bench for water_level_encoder: directed scenarios plus random probe traffic,
// all compared cycle by cycle against a behavioural model.
module tb_water_level_encoder;

  localparam int TD = 4;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] probe;
  logic [2:0] state;
  logic       fault;
  logic       changed;

  int checks = 0;
  int errors = 0;

  // model state: values expected just after the upcoming edge
  logic [6:0] m_acc;
  logic [2:0] m_state;
  logic       m_fault, m_changed;
  int         m_cyc;
  logic [6:0] phist[$];
  logic [6:0] samp[$];

  water_level_encoder #(.TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .probe(probe),
    .state(state), .fault(fault), .changed(changed)
  );

  always #5 clk = ~clk;

  // Advance model by one edge, then clock DUT; returns at the following negedge.
  task automatic cycle();
    logic [6:0] ps;
    int         k;
    logic       bad;
    logic [2:0] ns;
    bit         eq;
    if (rst) begin
      m_acc = '0; m_state = '0; m_fault = 0; m_changed = 0; m_cyc = 0;
      phist.delete(); samp.delete();
    end else begin
      ps = (phist.size() >= 2) ? phist[0] : 7'd0;
      phist.push_back(probe);
      if (phist.size() > 2) void'(phist.pop_front());
      k   = $countones(m_acc);
      bad = (int'(m_acc) != (1 << k) - 1);
      m_fault   = bad;
      m_changed = 0;
      if (m_cyc % TD == TD - 1) begin
        ns = m_state;
        if (!bad) begin
          if (int'(m_state) < k)      ns = m_state + 3'd1;
          else if (int'(m_state) > k) ns = m_state - 3'd1;
        end
`ifdef WATER_FAULT_ALARM_EN
        else ns = 3'd7;
`endif
        m_changed = (ns != m_state);
        m_state   = ns;
        samp.push_back(ps);
        if (samp.size() > SC) void'(samp.pop_front());
        if (samp.size() == SC) begin
          eq = 1;
          foreach (samp[i]) if (samp[i] != samp[0]) eq = 0;
          if (eq) m_acc = samp[0];
        end
      end
      m_cyc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [6:0] p);
    rst = 1; probe = p;
    repeat (2) cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    int first = 0, pulses = 0;
    rst = 1; probe = 7'h7F;
    repeat (3) begin
      cycle();
      checks++;
      if (state !== 3'd0 || fault !== 1'b0 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold state=%0d fault=%0b changed=%0b want 0 0 0", state, fault, changed);
      end
    end
    rst = 0;
    for (int i = 1; i <= 120 && first == 0; i++) begin
      cycle();
      checks += 2;
      if (state !== m_state) begin errors++; $display("FAIL reset_state got %0d want %0d", state, m_state); end
      if (changed !== m_changed) begin errors++; $display("FAIL reset_changed got %0b want %0b", changed, m_changed); end
      if (changed === 1'b1) pulses++;
      if (state === 3'd7) first = i;
    end
    checks += 2;
    if (first != 9 * TD) begin errors++; $display("FAIL reset_t7 got %0d want %0d", first, 9 * TD); end
    if (pulses != 7) begin errors++; $display("FAIL reset_pulses got %0d want 7", pulses); end
  endtask

  task automatic test_slew_up();
    int pulses = 0;
    do_reset(7'h00);
    repeat (20) cycle();
    probe = 7'h07;
    repeat (60) begin
      cycle();
      checks += 3;
      if (state !== m_state) begin errors++; $display("FAIL slew_state got %0d want %0d", state, m_state); end
      if (changed !== m_changed) begin errors++; $display("FAIL slew_changed got %0b want %0b", changed, m_changed); end
      if (fault !== m_fault) begin errors++; $display("FAIL slew_fault got %0b want %0b", fault, m_fault); end
      if (changed === 1'b1) pulses++;
    end
    checks += 2;
    if (state !== 3'd3) begin errors++; $display("FAIL slew_final got %0d want 3", state); end
    if (pulses != 3) begin errors++; $display("FAIL slew_pulses got %0d want 3", pulses); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset(7'h03);
    repeat (60) cycle();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL glitch_pre got %0d want 2", state); end
    probe = 7'h3F;
    repeat (3) cycle();
    probe = 7'h03;
    repeat (40) begin
      cycle();
      checks += 2;
      if (state !== 3'd2) begin errors++; $display("FAIL glitch_state got %0d want 2", state); end
      if (state !== m_state) begin errors++; $display("FAIL glitch_model got %0d want %0d", state, m_state); end
      if (changed === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_redirect();
    bit         hit = 0;
    logic [2:0] prev;
    do_reset(7'h00);
    repeat (12) cycle();
    probe = 7'h3F;
    for (int i = 0; i < 150 && !hit; i++) begin
      cycle();
      if (state === 3'd5) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL redirect_timeout state=%0d want 5", state); end
    probe = 7'h01;
    prev  = state;
    repeat (70) begin
      cycle();
      checks += 2;
      if (state !== m_state) begin errors++; $display("FAIL redirect_state got %0d want %0d", state, m_state); end
      if ((state > prev && state - prev > 1) || (prev > state && prev - state > 1)) begin
        errors++; $display("FAIL redirect_jump got %0d from %0d", state, prev);
      end
      prev = state;
    end
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL redirect_final got %0d want 1", state); end
  endtask

  task automatic test_invalid();
    int         pulses = 0;
    logic [2:0] mx = 0;
    do_reset(7'h07);
    repeat (60) cycle();
    probe = 7'h05;
    repeat (40) begin
      cycle();
      checks += 3;
      if (state !== m_state) begin errors++; $display("FAIL inv_state got %0d want %0d", state, m_state); end
      if (fault !== m_fault) begin errors++; $display("FAIL inv_fault got %0b want %0b", fault, m_fault); end
      if (changed !== m_changed) begin errors++; $display("FAIL inv_changed got %0b want %0b", changed, m_changed); end
      if (changed === 1'b1) pulses++;
      if (state > mx) mx = state;
    end
    checks += 3;
    if (fault !== 1'b1) begin errors++; $display("FAIL inv_fault_end got %0b want 1", fault); end
`ifdef WATER_FAULT_ALARM_EN
    if (mx !== 3'd7) begin errors++; $display("FAIL inv_max got %0d want 7", mx); end
    if (pulses != 1) begin errors++; $display("FAIL inv_pulses got %0d want 1", pulses); end
`else
    if (mx !== 3'd3) begin errors++; $display("FAIL inv_max got %0d want 3", mx); end
    if (pulses != 0) begin errors++; $display("FAIL inv_pulses got %0d want 0", pulses); end
`endif
    probe  = 7'h07;
    pulses = 0;
    repeat (60) begin
      cycle();
      checks += 2;
      if (state !== m_state) begin errors++; $display("FAIL rec_state got %0d want %0d", state, m_state); end
      if (fault !== m_fault) begin errors++; $display("FAIL rec_fault got %0b want %0b", fault, m_fault); end
      if (changed === 1'b1) pulses++;
    end
    checks += 3;
    if (state !== 3'd3) begin errors++; $display("FAIL rec_final got %0d want 3", state); end
    if (fault !== 1'b0) begin errors++; $display("FAIL rec_fault_end got %0b want 0", fault); end
`ifdef WATER_FAULT_ALARM_EN
    if (pulses != 4) begin errors++; $display("FAIL rec_pulses got %0d want 4", pulses); end
`else
    if (pulses != 0) begin errors++; $display("FAIL rec_pulses got %0d want 0", pulses); end
`endif
  endtask

  task automatic test_random();
    int k;
    do_reset(7'h00);
    repeat (80) begin
      if ($urandom_range(9) == 0) begin
        rst = 1;
      end else begin
        rst = 0;
        k = $urandom_range(7);
        probe = ($urandom_range(3) == 0) ? 7'($urandom) : 7'((1 << k) - 1);
      end
      repeat ($urandom_range(1, 30)) begin
        cycle();
        checks += 3;
        if (state !== m_state) begin errors++; $display("FAIL rand_state got %0d want %0d", state, m_state); end
        if (fault !== m_fault) begin errors++; $display("FAIL rand_fault got %0b want %0b", fault, m_fault); end
        if (changed !== m_changed) begin errors++; $display("FAIL rand_changed got %0b want %0b", changed, m_changed); end
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; probe = 7'h00;
    test_reset();
    test_slew_up();
    test_glitch();
    test_redirect();
    test_invalid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
